// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte transmitter.
// Holds the transaction state encoding and the quarter-bit divider calculation.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_ADDR_ACK = 3'd3,
    ST_DATA     = 3'd4,
    ST_DATA_ACK = 3'd5,
    ST_HOLD     = 3'd6,
    ST_STOP     = 3'd7
  } i2c_state_t;

  localparam logic        I2C_WRITE        = 1'b0;
  localparam int unsigned QUARTERS_PER_BIT = 32'd4;
  localparam logic [6:0]  ADDR_DEFAULT     = 7'h3C;

  // Number of system clocks per quarter of an SCL period.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned i2c_hz);
    return clk_hz / (QUARTERS_PER_BIT * i2c_hz);
  endfunction

endpackage

// File: rtl/i2c_byte_tx_if.sv
// Byte request/response handshake between the upstream controller and i2c_byte_tx.
// The physical SCL/SDA pins stay plain ports on the transmitter.
interface i2c_byte_tx_if;
  logic [7:0] data_in;
  logic       start;
  logic       last;
  logic       busy;
  logic       done;
  logic       ack_err;

  modport master (output data_in, output start, output last,
                  input  busy,    input  done,  input  ack_err);
  modport slave  (input  data_in, input  start, input  last,
                  output busy,    output done,  output ack_err);
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: one-cycle tick every DIV clocks.
// A synchronous clear restarts the phase so a new request starts a full quarter.
module i2c_tick_gen #(
  parameter int unsigned DIV = 32'd125
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  if (DIV < 32'd2) begin : g_div_check
    $fatal(1, "i2c_tick_gen: DIV must be at least 2");
  end

  localparam int unsigned   CW   = (DIV > 32'd2) ? $clog2(DIV) : 32'd1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Quarter-period counter with registered tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else if (clr) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CW'(1);
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/i2c_byte_tx.sv
// Single-master I2C write engine: START + address on the first byte, bus held
// between bytes, STOP after a byte flagged last. SDA is open-drain, SCL push-pull.
module i2c_byte_tx
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 32'd50_000_000,
  parameter int unsigned I2C_HZ   = 32'd100_000,
  parameter logic [6:0]  DEV_ADDR = ADDR_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  i2c_byte_tx_if.slave  bus,
  output logic          scl,
  inout  wire           sda
);

  localparam int unsigned DIV       = calc_div(CLK_HZ, I2C_HZ);
  localparam logic [7:0]  ADDR_BYTE = {DEV_ADDR, I2C_WRITE};
  localparam logic [1:0]  Q_LAST    = 2'(QUARTERS_PER_BIT - 32'd1);

  i2c_state_t state_r;
  logic [1:0] q_r;
  logic [2:0] bit_r;
  logic [7:0] tx_r;
  logic [7:0] data_r;
  logic       last_r;
  logic       nack_r;
  logic       scl_r;
  logic       sda_low_r;
  logic       busy_r;
  logic       done_r;
  logic       ack_err_r;
  logic       tick_s;
  logic       accept_s;

  assign accept_s = bus.start & ~busy_r & ((state_r == ST_IDLE) | (state_r == ST_HOLD));

  i2c_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept_s),
    .tick  (tick_s)
  );

  // Transaction sequencer; every pin level is registered with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      q_r       <= 2'd0;
      bit_r     <= 3'd0;
      tx_r      <= 8'd0;
      data_r    <= 8'd0;
      last_r    <= 1'b0;
      nack_r    <= 1'b0;
      scl_r     <= 1'b1;
      sda_low_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_START;
            q_r       <= 2'd0;
            scl_r     <= 1'b1;
            sda_low_r <= 1'b1;
            busy_r    <= 1'b1;
            ack_err_r <= 1'b0;
            data_r    <= bus.data_in;
            last_r    <= bus.last;
          end
        end
        ST_HOLD: begin
          // Bus already owned: continue straight into the data bits
          if (accept_s) begin
            state_r   <= ST_DATA;
            q_r       <= 2'd0;
            bit_r     <= 3'd7;
            sda_low_r <= ~bus.data_in[7];
            tx_r      <= {bus.data_in[6:0], 1'b0};
            data_r    <= bus.data_in;
            last_r    <= bus.last;
            busy_r    <= 1'b1;
          end
        end
        ST_START: begin
          if (tick_s) begin
            if (q_r == 2'd0) begin
              q_r   <= 2'd1;
              scl_r <= 1'b0;
            end else begin
              state_r   <= ST_ADDR;
              q_r       <= 2'd0;
              bit_r     <= 3'd7;
              sda_low_r <= ~ADDR_BYTE[7];
              tx_r      <= {ADDR_BYTE[6:0], 1'b0};
            end
          end
        end
        ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK: begin
          if (tick_s && (q_r != Q_LAST)) begin
            q_r   <= q_r + 2'd1;
            scl_r <= (q_r != 2'd2);
            if (q_r == 2'd1) begin
              nack_r <= sda;
            end
          end else if (tick_s) begin
            q_r <= 2'd0;
            case (state_r)
              ST_ADDR, ST_DATA: begin
                if (bit_r == 3'd0) begin
                  state_r   <= (state_r == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
                  sda_low_r <= 1'b0;
                end else begin
                  bit_r     <= bit_r - 3'd1;
                  sda_low_r <= ~tx_r[7];
                  tx_r      <= {tx_r[6:0], 1'b0};
                end
              end
              ST_ADDR_ACK: begin
                if (nack_r) begin
                  ack_err_r <= 1'b1;
                  state_r   <= ST_STOP;
                  sda_low_r <= 1'b1;
                end else begin
                  state_r   <= ST_DATA;
                  bit_r     <= 3'd7;
                  sda_low_r <= ~data_r[7];
                  tx_r      <= {data_r[6:0], 1'b0};
                end
              end
              default: begin
                if (nack_r || last_r) begin
                  ack_err_r <= ack_err_r | nack_r;
                  state_r   <= ST_STOP;
                  sda_low_r <= 1'b1;
                end else begin
                  state_r <= ST_HOLD;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                end
              end
            endcase
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            if (q_r == 2'd0) begin
              q_r   <= 2'd1;
              scl_r <= 1'b1;
            end else if (q_r == 2'd1) begin
              q_r       <= 2'd2;
              sda_low_r <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              q_r     <= 2'd0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign scl         = scl_r;
  assign sda         = sda_low_r ? 1'b0 : 1'bz;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.ack_err = ack_err_r;

endmodule

// File: tb/tb_i2c_byte_tx.sv
// Directed bench for i2c_byte_tx with a small I2C slave model on the pins.
// The slave ACKs every byte (optionally NACKs the address) and logs received bytes.
`timescale 1ns/1ps
module tb_i2c_byte_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  i2c_byte_tx_if bus ();
  logic scl;
  wire  sda;
  logic slave_low;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_byte_tx #(.CLK_HZ(50_000_000), .I2C_HZ(100_000), .DEV_ADDR(7'h3C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .scl   (scl),
    .sda   (sda)
  );

  int          cyc = 0;
  logic        mon_clr = 1'b1;
  logic        nack_addr = 1'b0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  int          bitc;
  logic [7:0]  sh;
  logic        first_byte;
  logic [31:0] rx_log;
  int          rx_n, n_start, n_stop, n_done;

  // Slave model and bus monitor: SDA edges while SCL is high count as START/STOP
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_scl <= scl;
    prev_sda <= sda;
    if (mon_clr) begin
      bitc <= 0; rx_log <= 32'd0; rx_n <= 0; n_start <= 0; n_stop <= 0;
      n_done <= 0; slave_low <= 1'b0; first_byte <= 1'b0; sh <= 8'd0;
    end else begin
      if (bus.done) n_done <= n_done + 1;
      if (scl && prev_scl && (sda != prev_sda)) begin
        bitc <= 0;
        if (!sda) begin
          n_start <= n_start + 1;
          first_byte <= 1'b1;
        end else begin
          n_stop <= n_stop + 1;
        end
      end else if (scl && !prev_scl) begin
        if (bitc < 8) begin
          sh   <= {sh[6:0], sda};
          bitc <= bitc + 1;
          if (bitc == 7) begin
            rx_log <= {rx_log[23:0], sh[6:0], sda};
            rx_n   <= rx_n + 1;
          end
        end else if (bitc == 8) begin
          bitc <= 9;
        end
      end else if (!scl && prev_scl) begin
        if (bitc == 8) begin
          slave_low <= !(first_byte && nack_addr);
        end else if (bitc == 9) begin
          slave_low  <= 1'b0;
          bitc       <= 0;
          first_byte <= 1'b0;
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass = 0;
  int acc_cyc = 0;
  int lat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    @(negedge clk); mon_clr = 1'b1;
    @(negedge clk); mon_clr = 1'b0;
  endtask

  // Called at a negedge; afterwards scrambles the inputs to prove they were latched
  task automatic do_start(input logic [7:0] d, input logic l);
    bus.data_in = d; bus.last = l; bus.start = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    bus.start = 1'b0; bus.data_in = ~d; bus.last = ~l;
    check_eq("busy_rise", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, output int l);
    int k;
    k = 0;
    while (!bus.done && k < 12000) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    check_eq({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    l = cyc - acc_cyc;
  endtask

  initial begin
    bus.start = 1'b0; bus.data_in = 8'd0; bus.last = 1'b0;
    #3 rst_n = 1'b0;
    tick_n(4);
    check_eq("rst_scl", 32'(scl), 32'd1);
    check_eq("rst_sda", 32'(sda), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_ack_err", 32'(bus.ack_err), 32'd0);
    rst_n = 1'b1;
    tick_n(2);
    mon_clr = 1'b0;
    tick_n(2);

    // single byte, 77 quarters of 125 clk
    do_start(8'hAE, 1'b1);
    wait_done("single", lat);
    check_eq("single_latency", 32'((lat >= 9623) && (lat <= 9627)), 32'd1);
    check_eq("single_ack_err", 32'(bus.ack_err), 32'd0);
    tick_n(5);
    check_eq("single_rx", rx_log[15:0], 32'h78AE);
    check_eq("single_rx_n", 32'(rx_n), 32'd2);
    check_eq("single_starts", 32'(n_start), 32'd1);
    check_eq("single_stops", 32'(n_stop), 32'd1);
    check_eq("single_dones", 32'(n_done), 32'd1);
    check_eq("single_idle_scl", 32'(scl), 32'd1);
    check_eq("single_idle_sda", 32'(sda), 32'd1);

    // two bytes, second requested in the done cycle of the first
    clear_mon();
    do_start(8'h20, 1'b0);
    wait_done("multi1", lat);
    check_eq("hold_scl", 32'(scl), 32'd0);
    check_eq("hold_sda", 32'(sda), 32'd1);
    do_start(8'h00, 1'b1);
    wait_done("multi2", lat);
    tick_n(5);
    check_eq("multi_rx", rx_log[23:0], 32'h782000);
    check_eq("multi_rx_n", 32'(rx_n), 32'd3);
    check_eq("multi_starts", 32'(n_start), 32'd1);
    check_eq("multi_stops", 32'(n_stop), 32'd1);
    check_eq("multi_dones", 32'(n_done), 32'd2);
    check_eq("multi_ack_err", 32'(bus.ack_err), 32'd0);

    // address NACK: 2+36+3 quarters, no data bits
    clear_mon();
    nack_addr = 1'b1;
    do_start(8'h55, 1'b1);
    wait_done("nack", lat);
    check_eq("nack_latency", 32'((lat >= 5123) && (lat <= 5127)), 32'd1);
    check_eq("nack_ack_err", 32'(bus.ack_err), 32'd1);
    tick_n(5);
    check_eq("nack_rx", rx_log[7:0], 32'h78);
    check_eq("nack_rx_n", 32'(rx_n), 32'd1);
    check_eq("nack_stops", 32'(n_stop), 32'd1);
    check_eq("nack_dones", 32'(n_done), 32'd1);
    check_eq("nack_sticky", 32'(bus.ack_err), 32'd1);
    nack_addr = 1'b0;
    clear_mon();
    do_start(8'h81, 1'b1);
    tick_n(3);
    check_eq("ack_err_cleared", 32'(bus.ack_err), 32'd0);
    wait_done("after_nack", lat);
    tick_n(5);
    check_eq("after_nack_rx", rx_log[15:0], 32'h7881);
    check_eq("after_nack_ack_err", 32'(bus.ack_err), 32'd0);

    // start while busy is ignored
    clear_mon();
    do_start(8'hC3, 1'b1);
    tick_n(1250);
    bus.data_in = 8'hFF; bus.last = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_ign", lat);
    check_eq("busy_ign_latency", 32'((lat >= 9623) && (lat <= 9627)), 32'd1);
    tick_n(200);
    check_eq("busy_ign_rx", rx_log[15:0], 32'h78C3);
    check_eq("busy_ign_rx_n", 32'(rx_n), 32'd2);
    check_eq("busy_ign_dones", 32'(n_done), 32'd1);
    check_eq("busy_ign_idle_busy", 32'(bus.busy), 32'd0);
    check_eq("busy_ign_idle_scl", 32'(scl), 32'd1);

    // reset during data bit 3 (value 0) while SCL is high
    clear_mon();
    do_start(8'hAE, 1'b1);
    tick_n(52 * 125 + 59);
    check_eq("pre_rst_scl", 32'(scl), 32'd1);
    check_eq("pre_rst_sda", 32'(sda), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_scl", 32'(scl), 32'd1);
    check_eq("mid_rst_sda", 32'(sda), 32'd1);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_done", 32'(bus.done), 32'd0);
    tick_n(4);
    rst_n = 1'b1;
    clear_mon();
    do_start(8'h96, 1'b1);
    wait_done("post_rst", lat);
    check_eq("post_rst_latency", 32'((lat >= 9623) && (lat <= 9627)), 32'd1);
    tick_n(5);
    check_eq("post_rst_rx", rx_log[15:0], 32'h7896);
    check_eq("post_rst_rx_n", 32'(rx_n), 32'd2);
    check_eq("post_rst_starts", 32'(n_start), 32'd1);
    check_eq("post_rst_stops", 32'(n_stop), 32'd1);
    check_eq("post_rst_dones", 32'(n_done), 32'd1);
    check_eq("post_rst_ack_err", 32'(bus.ack_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
